serial_mag_compare_ctrl: RTL and testbench

Sequential magnitude comparator for WIDTH-bit unsigned operands. It steps through the operands 2 bits per cycle, MSB slice first, and stops at the first slice that differs. Each slice is evaluated by the team's gate-level 2-bit greater-than cell, instantiated twice: once as (a,b) for greater-than and once as (b,a) for less-than. The block owns the sequencing and handshake around that cell, so wide compares cost only two small cells and no wide comparator.

---
 rtl/serial_mag_compare_ctrl.sv | 173 +++++++++++++++++
 tb/tb_serial_mag_compare_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_compare_ctrl.sv
`default_nettype none

// ============================================================================
//  Module   : gt2_cell
//  Purpose  : Gate-level 2-bit unsigned greater-than cell (gt = x > y).
//  Revision : 1.0  initial release
// ============================================================================
module gt2_cell (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       gt
);

    logic hi_gt;
    logic hi_eq;
    logic lo_gt;

    // The MSB decides unless the MSBs match, in which case the LSB decides.
    assign hi_gt = x[1] & ~y[1];
    assign hi_eq = ~(x[1] ^ y[1]);
    assign lo_gt = x[0] & ~y[0];
    assign gt    = hi_gt | (hi_eq & lo_gt);

endmodule

// ============================================================================
//  Module   : serial_mag_compare_ctrl
//  Purpose  : Sequential unsigned magnitude comparator. Walks the operands two
//             bits per cycle, MSB slice first, and stops at the first slice
//             that differs. Two gt2_cell instances ((a,b) and (b,a)) do all
//             the arithmetic; this block owns sequencing and the handshake.
//  Revision : 1.0  initial release
// ============================================================================
module serial_mag_compare_ctrl #(
    parameter int WIDTH = 8                 // must be even and >= 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             agtb,
    output logic             aeqb,
    output logic             altb
);

    localparam int                 N        = WIDTH / 2;
    localparam int                 IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               agtb_q, agtb_d;
    logic               aeqb_q, aeqb_d;
    logic               altb_q, altb_d;

    logic               slice_gt;
    logic               slice_lt;

    // Current top slice of each shift register feeds both cells; swapping the
    // operands on the second cell turns it into a less-than.
    gt2_cell u_slice_gt (
        .x  (sa_q[WIDTH-1:WIDTH-2]),
        .y  (sb_q[WIDTH-1:WIDTH-2]),
        .gt (slice_gt)
    );

    gt2_cell u_slice_lt (
        .x  (sb_q[WIDTH-1:WIDTH-2]),
        .y  (sa_q[WIDTH-1:WIDTH-2]),
        .gt (slice_lt)
    );

    // Next-state, datapath and result-flag logic for the compare sequence.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        idx_d   = idx_q;
        agtb_d  = agtb_q;
        aeqb_d  = aeqb_q;
        altb_d  = altb_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    idx_d   = IDX_LAST;
                    agtb_d  = 1'b0;
                    aeqb_d  = 1'b0;
                    altb_d  = 1'b0;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (slice_gt) begin
                    agtb_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (slice_lt) begin
                    altb_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    aeqb_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    // Zero fill keeps the cells fed with a defined value once
                    // the real slices are used up.
                    sa_d  = sa_q << 2;
                    sb_d  = sb_q << 2;
                    idx_d = idx_q - IDX_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the upcoming state.
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and output registers; reset aborts any compare in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            agtb_q  <= 1'b0;
            aeqb_q  <= 1'b0;
            altb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            agtb_q  <= agtb_d;
            aeqb_q  <= aeqb_d;
            altb_q  <= altb_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign agtb  = agtb_q;
    assign aeqb  = aeqb_q;
    assign altb  = altb_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_mag_compare_ctrl.sv
`default_nettype none

// ============================================================================
//  Module   : tb_serial_mag_compare_ctrl
//  Purpose  : Self-checking bench for serial_mag_compare_ctrl at WIDTH=8 and
//             WIDTH=2 using directed vectors and a reference compare model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_mag_compare_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8, start2;
    logic [7:0] a8, b8;
    logic [1:0] a2, b2;
    logic       ready8, done8, agtb8, aeqb8, altb8;
    logic       ready2, done2, agtb2, aeqb2, altb2;

    int errors = 0;
    int checks = 0;

    serial_mag_compare_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .ready (ready8),
        .done  (done8),
        .agtb  (agtb8),
        .aeqb  (aeqb8),
        .altb  (altb8)
    );

    serial_mag_compare_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .ready (ready2),
        .done  (done2),
        .agtb  (agtb2),
        .aeqb  (aeqb2),
        .altb  (altb2)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         k;
        logic [2:0] f;      // {agtb, aeqb, altb}
    } vec_t;

    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_EQ = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {ready, done, agtb, aeqb, altb} of the selected instance
    function automatic logic [4:0] outs(input int w);
        if (w == 8) return {ready8, done8, agtb8, aeqb8, altb8};
        return {ready2, done2, agtb2, aeqb2, altb2};
    endfunction

    task automatic drive(input int w, input logic s, input logic [7:0] av, input logic [7:0] bv);
        if (w == 8) begin
            start8 = s; a8 = av; b8 = bv;
        end else begin
            start2 = s; a2 = av[1:0]; b2 = bv[1:0];
        end
    endtask

    // Reference: scan 2-bit slices from the MSB, first difference decides.
    function automatic void model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                  output int k, output logic [2:0] f);
        logic [1:0] xa, xb;
        bit found;
        k = w / 2;
        f = F_EQ;
        found = 0;
        for (int i = 0; i < w / 2; i++) begin
            xa = 2'(av >> (w - 2 - 2 * i));
            xb = 2'(bv >> (w - 2 - 2 * i));
            if (!found && xa != xb) begin
                found = 1;
                k = i + 1;
                f = (xa > xb) ? F_GT : F_LT;
            end
        end
    endfunction

    // One full compare starting from IDLE; noise on a/b after acceptance.
    task automatic run_cmp(input int w, input logic [7:0] av, input logic [7:0] bv,
                           input int ek, input logic [2:0] ef, input string nm);
        logic [4:0] o;
        bit got;
        int kk;
        o = outs(w);
        chk({nm, " ready before start"}, int'(o[4]), 1);
        drive(w, 1'b1, av, bv);
        tick();                                          // E0
        drive(w, 1'b0, 8'($urandom), 8'($urandom));
        o = outs(w);
        chk({nm, " ready after accept"}, int'(o[4]), 0);
        chk({nm, " flags cleared"}, int'(o[2:0]), 0);
        got = 0;
        kk  = 0;
        for (int c = 1; c <= w / 2 + 2 && !got; c++) begin
            tick();
            o = outs(w);
            if (o[3]) begin
                got = 1;
                kk  = c;
            end else begin
                drive(w, 1'b0, 8'($urandom), 8'($urandom));
            end
        end
        if (!got) begin
            chk({nm, " done timeout"}, 0, 1);
        end else begin
            chk({nm, " latency"}, kk, ek);
            chk({nm, " flags"}, int'(o[2:0]), int'(ef));
        end
        tick();                                          // Ek+1
        o = outs(w);
        chk({nm, " done pulse width"}, int'(o[3]), 0);
        chk({nm, " ready after done"}, int'(o[4]), 1);
        chk({nm, " flags held"}, int'(o[2:0]), int'(ef));
    endtask

    initial begin
        vec_t       vecs [9];
        logic [4:0] o;
        logic [7:0] pa, pb, na, nb;
        int         next_acc, done_edge, mk;
        logic [2:0] mf, exp_f;

        vecs[0] = '{8'hC5, 8'h35, 1, F_GT};
        vecs[1] = '{8'h5A, 8'h5B, 4, F_LT};
        vecs[2] = '{8'hA7, 8'hA7, 4, F_EQ};
        vecs[3] = '{8'h00, 8'hFF, 1, F_LT};
        vecs[4] = '{8'hFF, 8'h00, 1, F_GT};
        vecs[5] = '{8'h5A, 8'h4A, 2, F_GT};
        vecs[6] = '{8'h6C, 8'h64, 3, F_GT};
        vecs[7] = '{8'h00, 8'h01, 4, F_LT};
        vecs[8] = '{8'h80, 8'hC0, 1, F_LT};

        reset = 1'b1;
        drive(8, 1'b0, 8'h00, 8'h00);
        drive(2, 1'b0, 8'h00, 8'h00);

        // Reset held for three cycles, then released
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset ready8/done8/flags8", int'(outs(8)), 5'b10000);
            chk("reset ready2/done2/flags2", int'(outs(2)), 5'b10000);
            tick();
        end
        reset = 1'b0;
        tick();
        chk("post-reset outputs8", int'(outs(8)), 5'b10000);
        chk("post-reset outputs2", int'(outs(2)), 5'b10000);

        // Directed vector table, flags must hold through idle cycles
        foreach (vecs[i]) begin
            run_cmp(8, vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].f, $sformatf("vec%0d", i));
            tick();
            tick();
            chk($sformatf("vec%0d flags held idle", i), int'(outs(8) & 5'b00111), int'(vecs[i].f));
        end

        // start held high, a/b changing every cycle
        pa = 8'hC5;
        pb = 8'h35;
        drive(8, 1'b1, pa, pb);
        next_acc  = 1;
        done_edge = -1;
        exp_f     = 3'b000;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == next_acc) begin
                model(8, pa, pb, mk, mf);
                done_edge = e + mk;
                next_acc  = e + mk + 2;
                exp_f     = mf;
            end
            o = outs(8);
            chk($sformatf("held-start done e%0d", e), int'(o[3]), int'(e == done_edge));
            chk($sformatf("held-start ready e%0d", e), int'(o[4]), int'(e == next_acc - 1));
            if (e == done_edge)
                chk($sformatf("held-start flags e%0d", e), int'(o[2:0]), int'(exp_f));
            na = (e % 3 == 0) ? 8'hA7 : 8'(e * 53 + 17);
            nb = (e % 3 == 0) ? 8'hA7 : (na ^ ((e % 2 == 1) ? 8'h03 : 8'h30));
            pa = na;
            pb = nb;
            drive(8, 1'b1, pa, pb);
        end
        drive(8, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) tick();

        // Reset in the middle of an equal-operand 4-slice compare
        drive(8, 1'b1, 8'h55, 8'h55);
        tick();                                          // E0
        drive(8, 1'b0, 8'h00, 8'h00);
        tick();                                          // E1
        tick();                                          // E2
        reset = 1'b1;
        #1;
        chk("abort outputs during reset", int'(outs(8)), 5'b10000);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("abort post-release c%0d", i), int'(outs(8)), 5'b10000);
        end

        // WIDTH=2 all operand pairs, then random traffic on both widths
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                model(2, 8'(x), 8'(y), mk, mf);
                run_cmp(2, 8'(x), 8'(y), mk, mf, $sformatf("w2 %0d/%0d", x, y));
            end
        end
        for (int i = 0; i < 1000; i++) begin
            na = 8'($urandom);
            nb = (i % 4 == 0) ? (na ^ 8'(1 << $urandom_range(0, 7))) : 8'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            model(8, na, nb, mk, mf);
            run_cmp(8, na, nb, mk, mf, $sformatf("rnd8 %02h/%02h", na, nb));
        end
        for (int i = 0; i < 1000; i++) begin
            na = 8'($urandom_range(0, 3));
            nb = 8'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) tick();
            model(2, na, nb, mk, mf);
            run_cmp(2, na, nb, mk, mf, $sformatf("rnd2 %0d/%0d", na, nb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
